// File: rtl/imem_uart_loader_if.sv
// CPU instruction-fetch bus: byte fetch address from the CPU, instruction word back.
interface imem_uart_loader_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/imem_uart_loader.sv
// Instruction RAM with UART (8N1) image loader that holds the CPU in reset while loading.
// Optional IMEM_LOADER_CHECKSUM_EN: trailing XOR checksum byte verified in a CHK state.
module imem_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH_LOG2   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  input  logic              load_req,
  imem_uart_loader_if.slave imem,
  output logic              cpu_reset,
  output logic              loading,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam int unsigned   DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_state_nxt;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]    rx_bit, rx_bit_nxt;
  logic [7:0]    rx_shift, rx_shift_nxt;
  logic          rx_valid, rx_valid_nxt;
  logic          rx_ferr, rx_ferr_nxt;
  logic [7:0]    rx_byte;

  assign rx_byte = rx_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
      rx_valid <= rx_valid_nxt;
      rx_ferr  <= rx_ferr_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + 1'b1;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_valid_nxt = 1'b0;
    rx_ferr_nxt  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = '0;
        if (!rx_sync) rx_state_nxt = RX_START;
      end
      RX_START: begin
        // Mid-bit recheck; a glitch that has already gone high is dropped silently.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt   = '0;
          rx_bit_nxt   = '0;
          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_nxt = RX_IDLE;
          rx_valid_nxt = rx_sync;
          rx_ferr_nxt  = !rx_sync;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------- Load state machine ----------------
  typedef enum logic [2:0] {
    L_RUN,
    L_HDR_LO,
    L_HDR_HI,
    L_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    L_CHK,
`endif
    L_ERR
  } ld_state_t;

  ld_state_t             state, state_nxt, end_state;
  logic [15:0]           n_words;
  logic [15:0]           hdr_n;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic [23:0]           byte_buf;
  logic                  start_load;
  logic                  mem_we;
  logic                  last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            chk;
`endif

  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    mem_we     = 1'b0;
    hdr_n      = {rx_byte, n_words[7:0]};
    last_word  = ((words_loaded + 16'd1) == n_words);
`ifdef IMEM_LOADER_CHECKSUM_EN
    end_state  = L_CHK;
`else
    end_state  = L_RUN;
`endif
    case (state)
      L_RUN, L_ERR: begin
        if (load_req) begin
          state_nxt  = L_HDR_LO;
          start_load = 1'b1;
        end
      end
      L_HDR_LO: begin
        if (rx_ferr)       state_nxt = L_ERR;
        else if (rx_valid) state_nxt = L_HDR_HI;
      end
      L_HDR_HI: begin
        if (rx_ferr) state_nxt = L_ERR;
        else if (rx_valid) begin
          if ({16'd0, hdr_n} > DEPTH) state_nxt = L_ERR;
          else if (hdr_n == 16'd0)    state_nxt = end_state;
          else                        state_nxt = L_DATA;
        end
      end
      L_DATA: begin
        if (rx_ferr) state_nxt = L_ERR;
        else if (rx_valid && lane == 2'd3) begin
          mem_we = 1'b1;
          if (last_word) state_nxt = end_state;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      L_CHK: begin
        if (rx_ferr)       state_nxt = L_ERR;
        else if (rx_valid) state_nxt = (rx_byte == chk) ? L_RUN : L_ERR;
      end
`endif
      default: state_nxt = L_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= L_RUN;
      cpu_reset    <= 1'b1;
      words_loaded <= '0;
      n_words      <= '0;
      idx          <= '0;
      lane         <= '0;
      byte_buf     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk          <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cpu_reset <= (state_nxt != L_RUN);
      if (start_load) begin
        words_loaded <= '0;
        idx          <= '0;
        lane         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk          <= '0;
`endif
      end else if (rx_valid) begin
        case (state)
          L_HDR_LO: n_words[7:0]  <= rx_byte;
          L_HDR_HI: n_words[15:8] <= rx_byte;
          L_DATA: begin
            // Bytes shift in from the top so b0 ends up in bits 7:0 after three bytes.
            lane     <= lane + 1'b1;
            byte_buf <= {rx_byte, byte_buf[23:8]};
            if (lane == 2'd3) begin
              idx <= idx + 1'b1;
              if (words_loaded != 16'hFFFF) words_loaded <= words_loaded + 16'd1;
            end
          end
          default: ;
        endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state == L_HDR_LO || state == L_HDR_HI || state == L_DATA) chk <= chk ^ rx_byte;
`endif
      end
    end
  end

  assign loading  = (state != L_RUN) && (state != L_ERR);
  assign load_err = (state == L_ERR);

  // ---------------- Instruction RAM (not reset) ----------------
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx] <= {rx_byte, byte_buf};
  end

  assign imem.imem_instr = mem[imem.imem_addr[DEPTH_LOG2+1:2]];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem.imem_addr[31:DEPTH_LOG2+2], imem.imem_addr[1:0]};

endmodule
